buffer_drain_ctrl: RTL

BUFFER_DRAIN_CTRL -- requirements
Module: buffer_drain_ctrl

---
 rtl/buffer_drain_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/buffer_drain_ctrl.sv
// Drains a contiguous range of a synchronous-read buffer onto a valid/ready stream.
// A 2-entry skid FIFO absorbs the one-cycle read latency so no issued read is ever lost.
module buffer_drain_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_entries,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q;
    logic [ADDR_WIDTH:0]     issue_left_q;
    logic [ADDR_WIDTH:0]     beat_left_q;
    logic                    inflight_q;
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic                    wr_idx_q;
    logic                    rd_idx_q;
    logic [1:0]              cnt_q;
    logic                    done_q;

    logic                    pop;
    logic                    issue;
    logic [2:0]              occupancy;
    logic [1:0]              cnt_d;

    // A read is issued only if its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        pop       = (cnt_q != 2'd0) && out_ready;
        occupancy = {1'b0, cnt_q} + {2'b00, inflight_q};
        issue     = (state_q == READ) && (issue_left_q != '0) &&
                    (occupancy < (3'd2 + {2'b00, pop}));
        cnt_d     = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            issue_left_q <= '0;
            beat_left_q  <= '0;
            inflight_q   <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_idx_q     <= 1'b0;
            rd_idx_q     <= 1'b0;
            cnt_q        <= 2'd0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            cnt_q      <= cnt_d;
            if (issue) begin
                rd_ptr_q     <= rd_ptr_q + ADDR_WIDTH'(1);
                issue_left_q <= issue_left_q - (ADDR_WIDTH+1)'(1);
            end
            if (inflight_q) begin
                fifo_q[wr_idx_q] <= q;
                wr_idx_q         <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q    <= ~rd_idx_q;
                beat_left_q <= beat_left_q - (ADDR_WIDTH+1)'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_entries != '0) begin
                            rd_ptr_q     <= start_addr;
                            issue_left_q <= num_entries;
                            beat_left_q  <= num_entries;
                            state_q      <= READ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && issue_left_q == (ADDR_WIDTH+1)'(1))
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (pop && beat_left_q == (ADDR_WIDTH+1)'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdaddress = rd_ptr_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_q[rd_idx_q];
    assign out_last  = out_valid && (beat_left_q == (ADDR_WIDTH+1)'(1));
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
